// File: rtl/wb_test_mbox_mem.sv
// wb_test_mbox_mem: Wishbone classic slave word RAM with byte selects, programmable
// ACK wait states and a hardware test mailbox with watchdog.
// Optional macro WB_MBOX_ERR_EN: out-of-range requests answer with o_wb_err instead of o_wb_ack.
module wb_test_mbox_mem #(
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned WAIT_CYCLES    = 0,
    parameter int unsigned MBOX_FLAG_ADDR = 320,
    parameter int unsigned MBOX_RES_ADDR  = 321,
    parameter int unsigned TIMEOUT        = 600,
    parameter int unsigned TO_W           = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    input  logic        i_test_start,
    input  logic [31:0] i_expected,
    output logic        o_test_done,
    output logic        o_test_pass,
    output logic        o_timeout,
    output logic [31:0] o_result
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned WCW = 4;
    localparam logic [AW-1:0] FLAG_IDX = AW'(MBOX_FLAG_ADDR);
    localparam logic [AW-1:0] RES_IDX  = AW'(MBOX_RES_ADDR);

    typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_ACK} bus_state_e;
    typedef enum logic [1:0] {T_STOP, T_RUN, T_DONE, T_TIMEOUT} test_state_e;

    logic [31:0]    mem_q [DEPTH];
    bus_state_e     bus_q, bus_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           inr_q, inr_d;
    logic           we_q, we_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    wdat_q, wdat_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [31:0]    rdat_q, rdat_d;

    test_state_e    test_q, test_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           to_q, to_d;
    logic [31:0]    res_q, res_d;

    logic           req_c;
    logic           in_range_c;
    logic           commit_c;
    logic           flag_done_c;
    logic [31:0]    merged_c;
    logic           unused_adr_c;

    assign req_c        = i_wb_cyc & i_wb_stb;
    assign in_range_c   = i_wb_adr[31:2] < 30'(DEPTH);
    assign unused_adr_c = ^i_wb_adr[1:0];

    // Byte-select merge of latched write data over the addressed RAM word
    always_comb begin
        merged_c = mem_q[idx_q];
        for (int n = 0; n < 4; n++) begin
            if (sel_q[n]) merged_c[8*n +: 8] = wdat_q[8*n +: 8];
        end
    end

    assign commit_c    = (bus_q == BUS_ACK) && we_q && inr_q && i_rst_n;
    assign flag_done_c = commit_c && (idx_q == FLAG_IDX) && merged_c[0];

    // RAM write port; a test start clears the flag word and overrides a same-cycle bus write to it
    always_ff @(posedge i_clk) begin
        if (commit_c) mem_q[idx_q] <= merged_c;
        if (i_rst_n && i_test_start) mem_q[FLAG_IDX] <= 32'h0;
    end

    // Bus FSM next state: request latch, wait-state count, abort, ACK/ERR slot and read data
    always_comb begin
        bus_d  = bus_q;
        wcnt_d = wcnt_q;
        idx_d  = idx_q;
        inr_d  = inr_q;
        we_d   = we_q;
        sel_d  = sel_q;
        wdat_d = wdat_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rdat_d = 32'h0;
        case (bus_q)
            BUS_IDLE: begin
                if (req_c) begin
                    idx_d  = i_wb_adr[AW+1:2];
                    inr_d  = in_range_c;
                    we_d   = i_wb_we;
                    sel_d  = i_wb_sel;
                    wdat_d = i_wb_dat;
                    wcnt_d = '0;
                    bus_d  = (WAIT_CYCLES == 0) ? BUS_ACK : BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                if (!req_c) begin
                    bus_d = BUS_IDLE;
                end else if (wcnt_q == WCW'(WAIT_CYCLES - 1)) begin
                    bus_d = BUS_ACK;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            BUS_ACK:  bus_d = BUS_IDLE;
            default:  bus_d = BUS_IDLE;
        endcase
        if (bus_d == BUS_ACK) begin
`ifdef WB_MBOX_ERR_EN
            ack_d = inr_d;
            err_d = !inr_d;
`else
            ack_d = 1'b1;
`endif
            rdat_d = inr_d ? mem_q[idx_d] : 32'h0;
        end
    end

    // Bus FSM state and registered bus outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus_q  <= BUS_IDLE;
            wcnt_q <= '0;
            idx_q  <= '0;
            inr_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            wdat_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            bus_q  <= bus_d;
            wcnt_q <= wcnt_d;
            idx_q  <= idx_d;
            inr_q  <= inr_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            wdat_q <= wdat_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
        end
    end

    // Test FSM next state: start, watchdog, done detection (done beats expiry)
    always_comb begin
        test_d = test_q;
        wd_d   = wd_q;
        done_d = done_q;
        pass_d = pass_q;
        to_d   = to_q;
        res_d  = res_q;
        if (i_test_start) begin
            test_d = T_RUN;
            wd_d   = '0;
            done_d = 1'b0;
            pass_d = 1'b0;
            to_d   = 1'b0;
        end else if (test_q == T_RUN) begin
            wd_d = wd_q + TO_W'(1);
            if (flag_done_c) begin
                test_d = T_DONE;
                done_d = 1'b1;
                res_d  = mem_q[RES_IDX];
                pass_d = (mem_q[RES_IDX] == i_expected);
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                test_d = T_TIMEOUT;
                to_d   = 1'b1;
            end
        end
    end

    // Test FSM state and registered mailbox outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            test_q <= T_STOP;
            wd_q   <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            to_q   <= 1'b0;
            res_q  <= '0;
        end else begin
            test_q <= test_d;
            wd_q   <= wd_d;
            done_q <= done_d;
            pass_q <= pass_d;
            to_q   <= to_d;
            res_q  <= res_d;
        end
    end

    assign o_wb_dat    = rdat_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_err    = err_q;
    assign o_test_done = done_q;
    assign o_test_pass = pass_q;
    assign o_timeout   = to_q;
    assign o_result    = res_q;

endmodule

// File: tb/tb_wb_test_mbox_mem.sv
// Bench for wb_test_mbox_mem (WAIT_CYCLES=2): bus vector table plus mailbox/watchdog sequences.
module tb_wb_test_mbox_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] o_dat;
    logic        o_ack;
    logic        o_err;
    logic        start;
    logic [31:0] expected;
    logic        done;
    logic        pass;
    logic        tmo;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

`ifdef WB_MBOX_ERR_EN
    localparam logic OOR_ACK = 1'b0;
    localparam logic OOR_ERR = 1'b1;
`else
    localparam logic OOR_ACK = 1'b1;
    localparam logic OOR_ERR = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic        exp_ack;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    wb_test_mbox_mem #(.WAIT_CYCLES(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wb_we      (wb_we),
        .i_wb_sel     (wb_sel),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .o_wb_dat     (o_dat),
        .o_wb_ack     (o_ack),
        .o_wb_err     (o_err),
        .i_test_start (start),
        .i_expected   (expected),
        .o_test_done  (done),
        .o_test_pass  (pass),
        .o_timeout    (tmo),
        .o_result     (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; returns data/ack/err and latency in clocks (0 if none within 10)
    task automatic bus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, output logic [31:0] rdat, output logic ack,
                       output logic err, output int lat);
        wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
        rdat = '0; ack = 1'b0; err = 1'b0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_ack || o_err) begin
                rdat = o_dat; ack = o_ack; err = o_err; lat = i;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        a, e, seen;
        int          lat;

        vecs[0]  = '{1'b1, 4'hF, 32'h14,   32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1,    1'b0};
        vecs[1]  = '{1'b1, 4'h5, 32'h14,   32'h1234_5678, 1'b0, 32'h0,         1'b1,    1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'h14,   32'h0,         1'b1, 32'hFF34_FF78, 1'b1,    1'b0};
        vecs[3]  = '{1'b1, 4'hF, 32'h18,   32'hAABB_CCDD, 1'b0, 32'h0,         1'b1,    1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h18,   32'h0,         1'b1, 32'hAABB_CCDD, 1'b1,    1'b0};
        vecs[5]  = '{1'b1, 4'h8, 32'h18,   32'h1122_3344, 1'b0, 32'h0,         1'b1,    1'b0};
        vecs[6]  = '{1'b0, 4'hF, 32'h18,   32'h0,         1'b1, 32'h11BB_CCDD, 1'b1,    1'b0};
        vecs[7]  = '{1'b1, 4'hF, 32'h0,    32'hCAFE_F00D, 1'b0, 32'h0,         1'b1,    1'b0};
        vecs[8]  = '{1'b0, 4'hF, 32'h1000, 32'h0,         1'b1, 32'h0,         OOR_ACK, OOR_ERR};
        vecs[9]  = '{1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF, 1'b0, 32'h0,         OOR_ACK, OOR_ERR};
        vecs[10] = '{1'b0, 4'hF, 32'h0,    32'h0,         1'b1, 32'hCAFE_F00D, 1'b1,    1'b0};
        vecs[11] = '{1'b0, 4'h2, 32'h14,   32'h0,         1'b1, 32'hFF34_FF78, 1'b1,    1'b0};

        rst_n = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_adr = '0; wb_dat = '0;
        wb_cyc = 1'b0; wb_stb = 1'b0; start = 1'b0; expected = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {27'h0, o_ack, o_err, done, pass, tmo}, 32'h0);
        chk("reset_dat", o_dat, 32'h0);
        chk("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bus vector table
        for (int v = 0; v < 12; v++) begin
            bus(vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].dat, rd, a, e, lat);
            chk($sformatf("vec%0d_ack", v), 32'(a), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd3);
            if (vecs[v].chk_dat) chk($sformatf("vec%0d_dat", v), rd, vecs[v].exp_dat);
        end

        // Abort during WAIT: no ACK, no write
        bus(1'b1, 4'hF, 32'h20, 32'h0, rd, a, e, lat);
        wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h20; wb_dat = 32'h55; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_ack || o_err) seen = 1'b1;
        end
        chk("abort_no_ack", 32'(seen), 32'h0);
        bus(1'b0, 4'hF, 32'h20, 32'h0, rd, a, e, lat);
        chk("abort_no_write", rd, 32'h0);

        // Passing test through the mailbox
        expected = 32'd21;
        pulse_start();
        bus(1'b1, 4'hF, 32'h504, 32'd21, rd, a, e, lat);
        bus(1'b1, 4'hF, 32'h500, 32'd1, rd, a, e, lat);
        chk("pass_done", 32'(done), 32'h1);
        chk("pass_pass", 32'(pass), 32'h1);
        chk("pass_result", result, 32'd21);
        chk("pass_timeout", 32'(tmo), 32'h0);

        // Reset in the middle of WAIT
        bus(1'b1, 4'hF, 32'h1C, 32'h1111_1111, rd, a, e, lat);
        wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h1C; wb_dat = 32'h2222_2222; wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwait_flags", {27'h0, o_ack, o_err, done, pass, tmo}, 32'h0);
        chk("rstwait_result", result, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        bus(1'b0, 4'hF, 32'h1C, 32'h0, rd, a, e, lat);
        chk("rstwait_ram", rd, 32'h1111_1111);

        // Watchdog expiry exactly TIMEOUT clocks after start
        pulse_start();
        repeat (599) @(negedge clk);
        chk("to_before", 32'(tmo), 32'h0);
        @(negedge clk);
        chk("to_at", 32'(tmo), 32'h1);
        bus(1'b1, 4'hF, 32'h500, 32'd1, rd, a, e, lat);
        chk("to_late_flag_done", 32'(done), 32'h0);
        chk("to_sticky", 32'(tmo), 32'h1);

        // Flag write acked on the expiry cycle: done wins, result mismatch
        bus(1'b1, 4'hF, 32'h504, 32'd2, rd, a, e, lat);
        expected = 32'd7;
        pulse_start();
        repeat (596) @(negedge clk);
        bus(1'b1, 4'h1, 32'h500, 32'd1, rd, a, e, lat);
        chk("race_lat", 32'(lat), 32'd3);
        chk("race_done", 32'(done), 32'h1);
        chk("race_timeout", 32'(tmo), 32'h0);
        chk("race_pass", 32'(pass), 32'h0);
        chk("race_result", result, 32'd2);

        // Restart clears status and the flag word
        pulse_start();
        chk("restart_flags", {29'h0, done, pass, tmo}, 32'h0);
        bus(1'b0, 4'hF, 32'h500, 32'h0, rd, a, e, lat);
        chk("restart_flag_word", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
